// File: rtl/conv3x3_pkg.sv
// conv3x3_pkg: shared kernel-select type and sizing helpers for the 3x3 filter.
package conv3x3_pkg;

  typedef enum logic [1:0] {
    PASS    = 2'd0,
    SMOOTH  = 2'd1,
    LAPLACE = 2'd2,
    SOBEL   = 2'd3
  } mode_e;

  // Cycles from a pixel being sampled to its filtered column appearing on data_o.
  localparam int LATENCY = 4;

  // Signed accumulator width: pixel width plus headroom for the 16x smooth sum
  // and the sign bit of the edge kernels.
  function automatic int acc_width(input int data_width);
    return data_width + 5;
  endfunction

endpackage

// File: rtl/conv3x3_window.sv
// conv3x3_window: builds a 3x3 neighbourhood from three vertically aligned
// row streams, replicating the first and last columns of each line and
// flushing the final column on the first blank cycle after the line.
import conv3x3_pkg::*;

module conv3x3_window #(
  parameter int DATA_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       de_i,
  input  logic [DATA_WIDTH-1:0]      data0_i,
  input  logic [DATA_WIDTH-1:0]      data1_i,
  input  logic [DATA_WIDTH-1:0]      data2_i,
  output logic [2:0][DATA_WIDTH-1:0] win_l,
  output logic [2:0][DATA_WIDTH-1:0] win_c,
  output logic [2:0][DATA_WIDTH-1:0] win_r,
  output logic                       win_valid
);

  logic                       armed;
  logic                       in_line;
  logic                       de_eff;
  logic [2:0][DATA_WIDTH-1:0] col_l;
  logic [2:0][DATA_WIDTH-1:0] col_c;
  logic [2:0][DATA_WIDTH-1:0] col_in;

  // Row 0 is the top line, row 2 the bottom line.
  assign col_in = {data2_i, data1_i, data0_i};

  // Pixels are only accepted once a blank cycle has been seen since reset,
  // so a line that was already running at reset release is dropped whole.
  assign de_eff = de_i & armed;

  // Column shift register with left-border replication on the first pixel and
  // right-border replication on the flush cycle; the window is registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed     <= 1'b0;
      in_line   <= 1'b0;
      win_valid <= 1'b0;
      col_l     <= '0;
      col_c     <= '0;
      win_l     <= '0;
      win_c     <= '0;
      win_r     <= '0;
    end else begin
      if (!de_i) begin
        armed <= 1'b1;
      end
      win_valid <= 1'b0;
      if (de_eff) begin
        in_line <= 1'b1;
        if (!in_line) begin
          col_l <= col_in;
          col_c <= col_in;
        end else begin
          col_l     <= col_c;
          col_c     <= col_in;
          win_l     <= col_l;
          win_c     <= col_c;
          win_r     <= col_in;
          win_valid <= 1'b1;
        end
      end else if (in_line) begin
        in_line   <= 1'b0;
        win_l     <= col_l;
        win_c     <= col_c;
        win_r     <= col_c;
        win_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv3x3_filter.sv
// conv3x3_filter: run-time selectable 3x3 kernel (pass, smooth, Laplacian,
// Sobel) with a per-frame mode latch and a three-stage arithmetic pipeline.
import conv3x3_pkg::*;

module conv3x3_filter #(
  parameter int DATA_WIDTH = 10,
  parameter int EDGE_SHIFT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vsync_i,
  input  logic [1:0]            mode_i,
  input  logic                  de_i,
  input  logic [DATA_WIDTH-1:0] data0_i,
  input  logic [DATA_WIDTH-1:0] data1_i,
  input  logic [DATA_WIDTH-1:0] data2_i,
  output logic                  de_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  localparam int ACC_W = acc_width(DATA_WIDTH);
  localparam logic [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};

  typedef logic signed [ACC_W-1:0] acc_t;

  function automatic acc_t ext(input logic [DATA_WIDTH-1:0] p);
    return signed'({{(ACC_W-DATA_WIDTH){1'b0}}, p});
  endfunction

  function automatic logic [ACC_W-1:0] abs_val(input acc_t x);
    return x[ACC_W-1] ? unsigned'(-x) : unsigned'(x);
  endfunction

  logic [2:0][DATA_WIDTH-1:0] win_l;
  logic [2:0][DATA_WIDTH-1:0] win_c;
  logic [2:0][DATA_WIDTH-1:0] win_r;
  logic                       win_valid;

  conv3x3_window #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_window (
    .clk      (clk),
    .rst      (rst),
    .de_i     (de_i),
    .data0_i  (data0_i),
    .data1_i  (data1_i),
    .data2_i  (data2_i),
    .win_l    (win_l),
    .win_c    (win_c),
    .win_r    (win_r),
    .win_valid(win_valid)
  );

  logic  vsync_q;
  mode_e mode_q;

  logic  a_valid;
  mode_e a_mode;
  acc_t  a_p0;
  acc_t  a_p1;

  logic  b_valid;
  mode_e b_mode;
  acc_t  b_sum;

  acc_t  tl, tc, tr, cl, cc, cr, bl, bc, br;
  acc_t  part0, part1;
  logic [ACC_W-1:0]      mag;
  logic [DATA_WIDTH-1:0] sat_val;

  assign tl = ext(win_l[0]);
  assign tc = ext(win_c[0]);
  assign tr = ext(win_r[0]);
  assign cl = ext(win_l[1]);
  assign cc = ext(win_c[1]);
  assign cr = ext(win_r[1]);
  assign bl = ext(win_l[2]);
  assign bc = ext(win_c[2]);
  assign br = ext(win_r[2]);

  // Latch the kernel select only on a rising edge of vsync.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q <= 1'b0;
      mode_q  <= PASS;
    end else begin
      vsync_q <= vsync_i;
      if (vsync_i && !vsync_q) begin
        mode_q <= mode_e'(mode_i);
      end
    end
  end

  // Split each kernel into two partial sums (for Sobel: Gx and Gy).
  always_comb begin
    part0 = '0;
    part1 = '0;
    unique case (mode_q)
      PASS: begin
        part0 = cc;
      end
      SMOOTH: begin
        part0 = (tl + (tc <<< 1) + tr) + (bl + (bc <<< 1) + br);
        part1 = (cl <<< 1) + (cc <<< 2) + (cr <<< 1);
      end
      LAPLACE: begin
        part0 = cc <<< 3;
        part1 = -(tl + tc + tr + cl + cr + bl + bc + br);
      end
      SOBEL: begin
        part0 = (tr + (cr <<< 1) + br) - (tl + (cl <<< 1) + bl);
        part1 = (bl + (bc <<< 1) + br) - (tl + (tc <<< 1) + tr);
      end
      default: begin
        part0 = '0;
      end
    endcase
  end

  // Stage A captures the partial sums together with the mode they used.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid <= 1'b0;
      a_mode  <= PASS;
      a_p0    <= '0;
      a_p1    <= '0;
    end else begin
      a_valid <= win_valid;
      a_mode  <= mode_q;
      a_p0    <= part0;
      a_p1    <= part1;
    end
  end

  // Stage B combines the partials; Sobel adds magnitudes rather than values.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_valid <= 1'b0;
      b_mode  <= PASS;
      b_sum   <= '0;
    end else begin
      b_valid <= a_valid;
      b_mode  <= a_mode;
      if (a_mode == SOBEL) begin
        b_sum <= signed'(abs_val(a_p0) + abs_val(a_p1));
      end else begin
        b_sum <= a_p0 + a_p1;
      end
    end
  end

  // Final scaling per kernel, then clamp to the pixel range.
  always_comb begin
    mag = '0;
    unique case (b_mode)
      PASS:    mag = unsigned'(b_sum);
      SMOOTH:  mag = unsigned'(b_sum + ACC_W'(8)) >> 4;
      LAPLACE: mag = abs_val(b_sum) >> EDGE_SHIFT;
      SOBEL:   mag = unsigned'(b_sum) >> EDGE_SHIFT;
      default: mag = '0;
    endcase
    if (mag > SAT_MAX) begin
      sat_val = '1;
    end else begin
      sat_val = mag[DATA_WIDTH-1:0];
    end
  end

  // Stage C drives the outputs; data_o holds its value between lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      de_o   <= 1'b0;
      data_o <= '0;
    end else begin
      de_o <= b_valid;
      if (b_valid) begin
        data_o <= sat_val;
      end
    end
  end

endmodule
